// File: rtl/display_arbiter_pkg.sv
// Shared definitions for the display arbiter: service one-hot codes,
// arbiter state encoding, BCD-to-segment table and a one-hot helper.
package display_arbiter_pkg;

    localparam logic [3:0] SVC_NONE = 4'b0000;
    localparam logic [3:0] SVC_1    = 4'b1000;
    localparam logic [3:0] SVC_2    = 4'b0100;
    localparam logic [3:0] SVC_3    = 4'b0010;
    localparam logic [3:0] SVC_4    = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_LOCKOUT = 2'd2
    } arb_state_t;

    // Segment patterns {g..a}, active-high, indexed by BCD digit 0..9.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    // True when exactly one bit of a 4-bit vector is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/display_arbiter_bcd_seg_decode.sv
// Combinational BCD digit to 7-segment decoder; codes 10..15 are blanked.
module bcd_seg_decode
    import display_arbiter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for valid digits, all segments off otherwise.
    always_comb begin
        seg = 7'b0000000;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end else begin
            seg = 7'b0000000;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Display arbiter: grants the shared 4-digit display to one service,
// falls back to the running clock, handles finish with a lockout, and
// scans the digits. Optional feature macro: CURSOR_BLINK_EN (blinks the
// digit under edit while a service is active).
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 8
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  svc_sel,
    input  logic [3:0]  finish,
    input  logic [15:0] time_num,
    input  logic [15:0] svc1_num,
    input  logic [15:0] svc2_num,
    input  logic [15:0] svc3_num,
    input  logic [15:0] svc4_num,
    input  logic [3:0]  cursor,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [3:0]  active_svc,
    output logic [3:0]  svc_led
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    arb_state_t    state_r, state_nx_s;
    logic [3:0]    grant_r, grant_nx_s;
    logic [DW-1:0] div_r;
    logic [1:0]    idx_r;
    logic          div_wrap_s;
    logic [15:0]   src_s;
    logic [3:0]    digit_s;
    logic [6:0]    seg_dec_s;
    logic [3:0]    anode_nx_s;
    logic [3:0]    anode_r;
    logic [6:0]    seg_r;

    assign div_wrap_s = (div_r == DIV_MAX);

    // Arbiter state and grant registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            grant_r <= SVC_NONE;
        end else begin
            state_r <= state_nx_s;
            grant_r <= grant_nx_s;
        end
    end

    // Next-state and next-grant: finish on the granted bit beats a switch move.
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (is_onehot4(svc_sel)) begin
                    state_nx_s = ST_ACTIVE;
                    grant_nx_s = svc_sel;
                end else begin
                    state_nx_s = ST_IDLE;
                    grant_nx_s = SVC_NONE;
                end
            end
            ST_ACTIVE: begin
                if ((finish & grant_r) != 4'b0000) begin
                    state_nx_s = ST_LOCKOUT;
                    grant_nx_s = SVC_NONE;
                end else if (svc_sel != grant_r) begin
                    state_nx_s = ST_IDLE;
                    grant_nx_s = SVC_NONE;
                end else begin
                    state_nx_s = ST_ACTIVE;
                    grant_nx_s = grant_r;
                end
            end
            ST_LOCKOUT: begin
                grant_nx_s = SVC_NONE;
                if (svc_sel == SVC_NONE) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LOCKOUT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                grant_nx_s = SVC_NONE;
            end
        endcase
    end

    // Scan divider and digit index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_r <= '0;
            idx_r <= 2'd0;
        end else if (div_wrap_s) begin
            div_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            div_r <= div_r + DW'(1);
            idx_r <= idx_r;
        end
    end

    // Display source: granted service while active, running clock otherwise.
    always_comb begin
        src_s = time_num;
        if (state_r == ST_ACTIVE) begin
            case (grant_r)
                SVC_1:   src_s = svc1_num;
                SVC_2:   src_s = svc2_num;
                SVC_3:   src_s = svc3_num;
                SVC_4:   src_s = svc4_num;
                default: src_s = time_num;
            endcase
        end else begin
            src_s = time_num;
        end
    end

    // Nibble of the source belonging to the digit currently scanned.
    always_comb begin
        digit_s = 4'h0;
        case (idx_r)
            2'd0:    digit_s = src_s[3:0];
            2'd1:    digit_s = src_s[7:4];
            2'd2:    digit_s = src_s[11:8];
            2'd3:    digit_s = src_s[15:12];
            default: digit_s = 4'h0;
        endcase
    end

    bcd_seg_decode u_dec (
        .bcd (digit_s),
        .seg (seg_dec_s)
    );

`ifdef CURSOR_BLINK_EN
    localparam int RW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] RND_MAX = RW'(BLINK_DIV - 1);

    logic [RW-1:0] rnd_r;
    logic          phase_r;
    logic          grant_evt_s;
    logic          round_end_s;

    assign grant_evt_s = (state_r == ST_IDLE) && (state_nx_s == ST_ACTIVE);
    assign round_end_s = div_wrap_s && (idx_r == 2'd3);

    // Blink phase: restarts on each grant, toggles every BLINK_DIV scan rounds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rnd_r   <= '0;
            phase_r <= 1'b0;
        end else if (grant_evt_s) begin
            rnd_r   <= '0;
            phase_r <= 1'b0;
        end else if ((state_r == ST_ACTIVE) && round_end_s) begin
            if (rnd_r == RND_MAX) begin
                rnd_r   <= '0;
                phase_r <= ~phase_r;
            end else begin
                rnd_r   <= rnd_r + RW'(1);
                phase_r <= phase_r;
            end
        end else begin
            rnd_r   <= rnd_r;
            phase_r <= phase_r;
        end
    end

    // Anode select, blanking the cursor digit during the off phase.
    always_comb begin
        anode_nx_s = ~(4'b0001 << idx_r);
        if ((state_r == ST_ACTIVE) && phase_r && cursor[idx_r]) begin
            anode_nx_s = 4'b1111;
        end else begin
            anode_nx_s = ~(4'b0001 << idx_r);
        end
    end
`else
    logic unused_cursor_s;
    assign unused_cursor_s = ^cursor;

    // Anode select: every digit lit in turn.
    always_comb begin
        anode_nx_s = ~(4'b0001 << idx_r);
    end
`endif

    // Registered anode and segment outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            anode_r <= 4'b1111;
            seg_r   <= 7'b0000000;
        end else begin
            anode_r <= anode_nx_s;
            seg_r   <= seg_dec_s;
        end
    end

    assign anode      = anode_r;
    assign seg        = seg_r;
    assign active_svc = grant_r;
    assign svc_led    = grant_r;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios followed by
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_display_arbiter;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  svc_sel, finish, cursor;
    logic [15:0] time_num, svc1_num, svc2_num, svc3_num, svc4_num;
    logic [3:0]  anode, active_svc, svc_led;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 = showing clock/free, 1 = service owns display, 2 = waiting for switches down
    int         m_mode;
    logic [3:0] m_grant;
    int         m_cnt;
    int         m_rounds;
    logic [3:0] exp_anode;
    logic [6:0] exp_seg;
    logic [3:0] exp_grant;

    display_arbiter #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .svc_sel    (svc_sel),
        .finish     (finish),
        .time_num   (time_num),
        .svc1_num   (svc1_num),
        .svc2_num   (svc2_num),
        .svc3_num   (svc3_num),
        .svc4_num   (svc4_num),
        .cursor     (cursor),
        .anode      (anode),
        .seg        (seg),
        .active_svc (active_svc),
        .svc_led    (svc_led)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_grant   = 4'b0000;
        m_cnt     = 0;
        m_rounds  = 0;
        exp_anode = 4'b1111;
        exp_seg   = 7'b0000000;
        exp_grant = 4'b0000;
    endtask

    task automatic check_outputs();
        check("anode", {12'h000, anode}, {12'h000, exp_anode});
        check("seg", {9'h000, seg}, {9'h000, exp_seg});
        check("active_svc", {12'h000, active_svc}, {12'h000, exp_grant});
        check("svc_led", {12'h000, svc_led}, {12'h000, exp_grant});
    endtask

    // Called at a falling edge with inputs set: predicts the next rising edge, then checks.
    task automatic tick();
        int          idx;
        logic [15:0] src;
        int          nxt_mode;
        logic [3:0]  nxt_grant;
        idx = (m_cnt / SCAN_DIV) % 4;
        src = time_num;
        if (m_mode == 1) begin
            if (m_grant == 4'b1000) src = svc1_num;
            else if (m_grant == 4'b0100) src = svc2_num;
            else if (m_grant == 4'b0010) src = svc3_num;
            else if (m_grant == 4'b0001) src = svc4_num;
        end
        exp_seg   = seg_of(src[idx*4 +: 4]);
        exp_anode = ~(4'b0001 << idx);
`ifdef CURSOR_BLINK_EN
        if (m_mode == 1 && ((m_rounds / BLINK_DIV) % 2 == 1) && cursor[idx]) exp_anode = 4'b1111;
`endif
        nxt_mode  = m_mode;
        nxt_grant = m_grant;
        if (m_mode == 0) begin
            if ($countones(svc_sel) == 1) begin
                nxt_mode  = 1;
                nxt_grant = svc_sel;
            end
        end else if (m_mode == 1) begin
            if ((finish & m_grant) != 4'b0000) begin
                nxt_mode  = 2;
                nxt_grant = 4'b0000;
            end else if (svc_sel != m_grant) begin
                nxt_mode  = 0;
                nxt_grant = 4'b0000;
            end
        end else begin
            nxt_grant = 4'b0000;
            if (svc_sel == 4'b0000) nxt_mode = 0;
        end
        if (m_mode == 0 && nxt_mode == 1) m_rounds = 0;
        else if (m_mode == 1 && ((m_cnt + 1) % (4 * SCAN_DIV) == 0)) m_rounds++;
        m_cnt++;
        m_mode    = nxt_mode;
        m_grant   = nxt_grant;
        exp_grant = nxt_grant;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        resetn   = 1'b0;
        svc_sel  = 4'b0000;
        finish   = 4'b0000;
        cursor   = 4'b0000;
        time_num = 16'h1234;
        svc1_num = 16'h5678;
        svc2_num = 16'h0930;
        svc3_num = 16'h4321;
        svc4_num = 16'h9999;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        resetn = 1'b1;

        // Clock display only, then S2 grant
        repeat (20) tick();
        svc_sel = 4'b0100;
        repeat (20) tick();
        // Finish S2 with switch still up: lockout, no re-grant
        finish = 4'b0100;
        tick();
        finish = 4'b0000;
        repeat (10) tick();
        svc_sel = 4'b0000;
        repeat (2) tick();
        svc_sel = 4'b1000;
        repeat (8) tick();
        // Multi-hot from idle is ignored
        svc_sel = 4'b0000;
        tick();
        svc_sel = 4'b1100;
        repeat (4) tick();
        // Non-granted finish ignored; finish wins over simultaneous switch drop
        svc_sel = 4'b1000;
        repeat (3) tick();
        finish = 4'b0010;
        repeat (3) tick();
        finish  = 4'b1000;
        svc_sel = 4'b0000;
        tick();
        finish = 4'b0000;
        repeat (4) tick();
        // Cursor digit while S3 active, long enough for several blink periods
        svc_sel = 4'b0010;
        cursor  = 4'b0010;
        repeat (80) tick();

        // Asynchronous reset while active
        resetn = 1'b0;
        #1;
        check("rst_anode", {12'h000, anode}, 16'h000f);
        check("rst_seg", {9'h000, seg}, 16'h0000);
        check("rst_active", {12'h000, active_svc}, 16'h0000);
        check("rst_led", {12'h000, svc_led}, 16'h0000);
        @(negedge clk);
        model_reset();
        resetn = 1'b1;
        repeat (6) tick();

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 7))
                    0:       svc_sel = 4'b0000;
                    1:       svc_sel = 4'b1000;
                    2:       svc_sel = 4'b0100;
                    3:       svc_sel = 4'b0010;
                    4:       svc_sel = 4'b0001;
                    default: svc_sel = 4'($urandom);
                endcase
            end
            finish = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 19) == 0) time_num = 16'($urandom);
            if ($urandom_range(0, 19) == 0) svc1_num = 16'($urandom);
            if ($urandom_range(0, 19) == 0) svc2_num = 16'($urandom);
            if ($urandom_range(0, 19) == 0) svc3_num = 16'($urandom);
            if ($urandom_range(0, 19) == 0) svc4_num = 16'($urandom);
            if ($urandom_range(0, 29) == 0) cursor = 4'b0001 << $urandom_range(0, 3);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
